mem_arbiter: RTL and testbench

- Two-master arbiter that shares the single-port 256x16 RAM and the memory-mapped I/O between requesters.
- The I/O consists of the LED register at 0x100 and the switch port at 0x140.
- Master 0 is the CPU memory port; master 1 is a loader/debug port.
- Each master gets a registered request/acknowledge handshake, round-robin fairness and uniform two-cycle access latency, hiding the RAM's one-cycle read latency and the address decode.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a 256x16 synchronous RAM plus the
// LED register and switch port; every access takes a fixed two cycles to ack.
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here
// ISSUE | RAM address/write presented, LED written, switches sampled
// DATA  | RAM read data available, owner acked
module mem_arbiter #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        cmd0,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [7:0]        ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  state_t              state, state_nxt;
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          sw_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic [DATA_W-1:0]   rd_value;
  logic                grant;
  logic                winner;

  // Contention goes to the master that did not win last time.
  assign grant  = req0 | req1;
  assign winner = (req0 & req1) ? ~owner : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ram_write = (state == ISSUE) && (cmd_q == CMD_WR) && !addr_q[ADDR_W-1];
    ack0      = (state == DATA) && !owner;
    ack1      = (state == DATA) && owner;
    rd_value  = '0;
    if (!addr_q[ADDR_W-1])    rd_value = ram_dout;
    else if (addr_q == SW_ADDR) rd_value = {{(DATA_W-8){1'b0}}, sw_q};
    // RAM data only arrives in DATA, so the read result bypasses the hold register.
    rdata0 = (ack0 && cmd_q == CMD_RD) ? rd_value : rdata0_q;
    rdata1 = (ack1 && cmd_q == CMD_RD) ? rd_value : rdata1_q;
  end

  assign ram_addr = addr_q[7:0];
  assign ram_din  = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner    <= 1'b1;
      led      <= '0;
      sw_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= rdata0;
      rdata1_q <= rdata1;
      if (state == IDLE && grant) begin
        owner   <= winner;
        cmd_q   <= winner ? cmd1 : cmd0;
        addr_q  <= winner ? addr1 : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
      end
      if (state == ISSUE) begin
        sw_q <= sw;
        if (cmd_q == CMD_WR && addr_q == LED_ADDR) led <= wdata_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory-map model predicts each ack's
// rdata/led/owner, a negedge monitor compares as acks appear.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  cmd0 = '0, cmd1 = '0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = '0;
  logic [7:0]  sw = '0;
  logic [7:0]  led;
  logic        busy, owner;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
    .ram_dout(ram_dout), .sw(sw), .led(led), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  logic [15:0] tb_ram [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_write) tb_ram[ram_addr] <= ram_din;
    ram_dout <= tb_ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain memory map plus round-robin owner.
  typedef struct {
    int          m;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [7:0]  led;
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_m [256] = '{default: 16'h0000};
  logic [7:0]  led_m = '0;
  logic        owner_m = 1'b1;
  logic [15:0] rd_m [2] = '{16'h0, 16'h0};
  int          ack_cyc[$];

  task automatic model_push(input int m, input logic [1:0] c, input logic [8:0] a,
                            input logic [15:0] d, input logic [7:0] s);
    exp_t e;
    if (c == 2'b10) begin
      if (a < 9'h100)       mem_m[a[7:0]] = d;
      else if (a == 9'h100) led_m = d[7:0];
    end
    if (c == 2'b01) begin
      if (a < 9'h100)       rd_m[m] = mem_m[a[7:0]];
      else if (a == 9'h140) rd_m[m] = {8'h00, s};
      else                  rd_m[m] = 16'h0000;
    end
    owner_m = (m == 1);
    e.m = m; e.r0 = rd_m[0]; e.r1 = rd_m[1]; e.led = led_m;
    e.wr = (c == 2'b10) && (a < 9'h100);
    e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    owner_m = 1'b1; led_m = '0; rd_m[0] = '0; rd_m[1] = '0;
  endtask

  // Monitor
  int   wr_pulses = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      if (ram_write) begin
        wr_pulses++;
        if (exp_q.size() == 0) check("ram_write_spurious", 1, 0);
        else begin
          check("ram_write_allowed", 1, {31'd0, exp_q[0].wr});
          check("ram_addr", {24'd0, ram_addr}, {24'd0, exp_q[0].addr[7:0]});
          check("ram_din", {16'd0, ram_din}, {16'd0, exp_q[0].wdata});
        end
      end
      if (ack0 || ack1) begin
        check("ack_onehot", {31'd0, ack0 && ack1}, 0);
        if (exp_q.size() == 0) check("ack_spurious", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("ack_master", {31'd0, ack1}, mon_e.m);
          check("rdata0", {16'd0, rdata0}, {16'd0, mon_e.r0});
          check("rdata1", {16'd0, rdata1}, {16'd0, mon_e.r1});
          check("led", {24'd0, led}, {24'd0, mon_e.led});
          check("owner", {31'd0, owner}, mon_e.m);
          check("ram_write_pulses", wr_pulses, {31'd0, mon_e.wr});
          ack_cyc.push_back(cyc);
        end
        wr_pulses = 0;
      end
    end
  end

  task automatic drive(input int m, input logic r, input logic [1:0] c,
                       input logic [8:0] a, input logic [15:0] d);
    if (m == 0) begin req0 = r; cmd0 = c; addr0 = a; wdata0 = d; end
    else        begin req1 = r; cmd1 = c; addr1 = a; wdata1 = d; end
  endtask

  task automatic wait_ack(input int m, input int limit, output int n);
    bit got = 0;
    n = 0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (m == 0 ? ack0 : ack1) got = 1;
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  // Called at posedge+1 with the arbiter idle; returns at posedge+1 after DATA.
  task automatic txn(input int m, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    int n;
    model_push(m, c, a, d, sw);
    drive(m, 1'b1, c, a, d);
    wait_ack(m, 20, n);
    check("latency", n, 3);
    @(posedge clk); #1;
    drive(m, 1'b0, c, a, d);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_no_ack", {30'd0, ack0, ack1}, 0);
    check("held_rdata0", {16'd0, rdata0}, {16'd0, rd_m[0]});
    check("held_rdata1", {16'd0, rdata1}, {16'd0, rd_m[1]});
    @(posedge clk); #1;
  endtask

  task automatic reset_check();
    @(negedge clk);
    check("rst_ack", {30'd0, ack0, ack1}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ram_write", {31'd0, ram_write}, 0);
    check("rst_led", {24'd0, led}, 0);
    check("rst_owner", {31'd0, owner}, 1);
    check("rst_rdata", {rdata0, rdata1}, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_master(input int m, input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                            input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1);
    int n;
    drive(m, 1'b1, c0, a0, d0);
    wait_ack(m, 30, n);
    @(posedge clk); #1;
    drive(m, 1'b1, c1, a1, d1);
    wait_ack(m, 30, n);
    @(posedge clk); #1;
    drive(m, 1'b0, c1, a1, d1);
  endtask

  initial begin
    int m;
    logic [1:0] c;
    logic [8:0] a;
    int kind;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    reset_check();

    // Both masters contend continuously: expect 0,1,0,1 three cycles apart.
    ack_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      if (!owner_m) model_push(1, 2'b01, (k < 2) ? 9'h020 : 9'h021, 16'h0, sw);
      else          model_push(0, 2'b10, (k < 2) ? 9'h020 : 9'h021, (k < 2) ? 16'h1111 : 16'h2222, sw);
    end
    fork
      run_master(0, 2'b10, 9'h020, 16'h1111, 2'b10, 9'h021, 16'h2222);
      run_master(1, 2'b01, 9'h020, 16'h0000, 2'b01, 9'h021, 16'h0000);
    join
    check("rr_ack_count", ack_cyc.size(), 4);
    for (int k = 1; k < ack_cyc.size(); k++) check("rr_ack_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
    idle_check();

    txn(0, 2'b10, 9'h005, 16'hBEEF);  idle_check();
    txn(1, 2'b01, 9'h005, 16'h0000);  idle_check();
    txn(0, 2'b10, 9'h100, 16'h00A5);  idle_check();
    check("led_a5", {24'd0, led}, 32'hA5);
    txn(0, 2'b01, 9'h100, 16'h0000);  idle_check();
    sw = 8'h3C;
    txn(1, 2'b01, 9'h140, 16'h0000);  idle_check();
    txn(1, 2'b01, 9'h1FF, 16'h0000);  idle_check();
    txn(0, 2'b10, 9'h140, 16'hFFFF);
    txn(0, 2'b10, 9'h1FF, 16'hFFFF);
    txn(1, 2'b11, 9'h005, 16'h7777);
    txn(0, 2'b00, 9'h100, 16'h00FF);
    txn(0, 2'b01, 9'h005, 16'h0000);  idle_check();

    // Reset during the ISSUE cycle of a write must abort it cleanly.
    txn(0, 2'b10, 9'h010, 16'h5555);
    drive(0, 1'b1, 2'b10, 9'h010, 16'h1234);
    @(posedge clk); #1;
    check("abort_in_issue", {31'd0, busy}, 1);
    check("abort_ram_write_before", {31'd0, ram_write}, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_ram_write", {31'd0, ram_write}, 0);
    check("abort_led", {24'd0, led}, 0);
    drive(0, 1'b0, 2'b00, 9'h000, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    reset_check();
    txn(1, 2'b01, 9'h010, 16'h0000);  idle_check();
    txn(0, 2'b10, 9'h100, 16'h0042);  idle_check();

    // Randomised single-requester traffic, back to back.
    for (int i = 0; i < 80; i++) begin
      m    = $urandom_range(0, 1);
      c    = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 5);
      case (kind)
        3:       a = 9'h100;
        4:       a = 9'h140;
        5:       a = {1'b1, 8'($urandom)};
        default: a = {5'd0, 4'($urandom)};
      endcase
      sw = 8'($urandom);
      txn(m, c, a, 16'($urandom));
    end
    idle_check();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
